// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    MEM_WAIT  = 2'd2,
    FLUSH     = 2'd3
  } hc_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int REG_AW_DEF = 4;

endpackage

// File: rtl/hazard_controller_fwd_unit.sv
// Forwarding select for one ALU source operand; the younger (EX) producer wins over MEM.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_src,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_wbs,
  input  logic              ex_mm,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wbs,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_REG;
    if (use_src) begin
      // A load in EX has no result yet; that case is a load-use stall, not a forward.
      if (ex_wbs && !ex_mm && (ex_dest == rs)) begin
        sel = FWD_EX;
      end else if (mem_wbs && (mem_dest == rs)) begin
        sel = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/bubble/flush sequencing for the ID/EX and EX/MEM registers plus ALU forwarding selects.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int LOAD_STALL  = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] ex_reg_dest,
  input  logic              ex_wbs,
  input  logic              ex_mm,
  input  logic              ex_branch,
  input  logic [REG_AW-1:0] mem_reg_dest,
  input  logic              mem_wbs,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              hold_fd,
  output logic              hold_de,
  output logic              hold_em,
  output logic              bubble_de,
  output logic              flush_fd,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hc_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]        lw_cnt_q, lw_cnt_d;
  logic              timeout_q, timeout_d;
  logic              rel_q, rel_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       hold_fd_c, hold_de_c, hold_em_c, bubble_c, flush_c;
  logic       eval_run, mem_hold, load_use;
  logic [1:0] fwd_a_c, fwd_b_c;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(id_rs_a), .use_src(id_use_a), .ex_dest(ex_reg_dest), .ex_wbs(ex_wbs),
    .ex_mm(ex_mm), .mem_dest(mem_reg_dest), .mem_wbs(mem_wbs), .sel(fwd_a_c)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(id_rs_b), .use_src(id_use_b), .ex_dest(ex_reg_dest), .ex_wbs(ex_wbs),
    .ex_mm(ex_mm), .mem_dest(mem_reg_dest), .mem_wbs(mem_wbs), .sel(fwd_b_c)
  );

  // rel_q masks the access that timed out so the pipeline is not immediately re-stalled by it.
  assign mem_hold = mem_req && !mem_ready && !rel_q;
  assign load_use = ex_mm && ex_wbs &&
                    ((id_use_a && (id_rs_a == ex_reg_dest)) ||
                     (id_use_b && (id_rs_b == ex_reg_dest)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lw_cnt_d   = lw_cnt_q;
    timeout_d  = timeout_q;
    rel_d      = rel_q;
    hold_fd_c  = 1'b0;
    hold_de_c  = 1'b0;
    hold_em_c  = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    eval_run   = 1'b0;

    if (rel_q && (!mem_req || mem_ready)) begin
      rel_d = 1'b0;
    end

    unique case (state_q)
      RUN: eval_run = 1'b1;
      MEM_WAIT: begin
        if (mem_ready || !mem_req) begin
          wait_cnt_d = '0;
          eval_run   = 1'b1;
        end else begin
          hold_fd_c = 1'b1;
          hold_de_c = 1'b1;
          hold_em_c = 1'b1;
          if ((wait_cnt_q + WAIT_W'(1)) >= WAIT_W'(MEM_TIMEOUT)) begin
            timeout_d  = 1'b1;
            rel_d      = 1'b1;
            wait_cnt_d = '0;
            state_d    = RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_hold || ex_branch) begin
          eval_run = 1'b1;
        end else begin
          hold_fd_c = 1'b1;
          bubble_c  = 1'b1;
          if (lw_cnt_q <= 2'd1) begin
            lw_cnt_d = '0;
            state_d  = RUN;
          end else begin
            lw_cnt_d = lw_cnt_q - 2'd1;
          end
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase

    // Hazard priority: memory wait, then branch flush, then load-use.
    if (eval_run) begin
      lw_cnt_d = '0;
      if (mem_hold) begin
        hold_fd_c  = 1'b1;
        hold_de_c  = 1'b1;
        hold_em_c  = 1'b1;
        wait_cnt_d = WAIT_W'(1);
        state_d    = MEM_WAIT;
      end else if (ex_branch) begin
        flush_c = 1'b1;
        bubble_c = 1'b1;
        state_d = FLUSH;
      end else if (load_use) begin
        hold_fd_c = 1'b1;
        bubble_c  = 1'b1;
        if (LOAD_STALL > 1) begin
          lw_cnt_d = 2'(LOAD_STALL - 1);
          state_d  = LOAD_WAIT;
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (hold_fd_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      lw_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      rel_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lw_cnt_q    <= lw_cnt_d;
      timeout_q   <= timeout_d;
      rel_q       <= rel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted, regardless of the live inputs.
  assign hold_fd     = rst_n && hold_fd_c;
  assign hold_de     = rst_n && hold_de_c;
  assign hold_em     = rst_n && hold_em_c;
  assign bubble_de   = rst_n && bubble_c;
  assign flush_fd    = rst_n && flush_c;
  assign fwd_a_sel   = rst_n ? fwd_a_c : FWD_REG;
  assign fwd_b_sel   = rst_n ? fwd_b_c : FWD_REG;
  assign mem_timeout = timeout_q;
  assign stall_count = stall_cnt_q;

endmodule
